// File: rtl/writeback_sequencer.sv
// writeback_sequencer
//
// Purpose: arbitrates register-file writeback between single-cycle ALU results
// and a single outstanding data-memory load. ALU results are written in the
// cycle they are accepted. A load is issued in IDLE and written back,
// combinationally, in the cycle MemAck arrives. If an ALU result arrives in the
// same cycle as the load data, the load wins. The ALU result is then parked in a
// one-entry buffer and written on the following cycle.
//
// Parameters:
//   Data_Width  - width of the result datapath
//   Reg_Width   - width of a register index
//
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   AluValid/AluRd/ALUResult - ALU result presented for writeback
//   LoadReq/LoadRd          - load request and its destination register
//   MemReq, MemAck          - outstanding memory read / read data valid this cycle
//   Stall                   - upstream must hold all inputs
//   RegWrite/WbRd/ResultSrc/WbALUResult - regfile write port and result mux control
//   StallCount              - saturating count of stall cycles

module writeback_sequencer #(
    parameter int Data_Width = 32,
    parameter int Reg_Width  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  AluValid,
    input  logic [Reg_Width-1:0]  AluRd,
    input  logic [Data_Width-1:0] ALUResult,
    input  logic                  LoadReq,
    input  logic [Reg_Width-1:0]  LoadRd,
    output logic                  MemReq,
    input  logic                  MemAck,
    output logic                  Stall,
    output logic                  RegWrite,
    output logic [Reg_Width-1:0]  WbRd,
    output logic                  ResultSrc,
    output logic [Data_Width-1:0] WbALUResult,
    output logic [15:0]           StallCount
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t                state;
    state_t                next_state;

    logic                  buf_valid;
    logic [Reg_Width-1:0]  buf_rd;
    logic [Data_Width-1:0] buf_data;
    logic [Reg_Width-1:0]  pend_rd;

    logic                  alu_accept;
    logic                  load_accept;
    logic                  load_wb;
    logic                  buf_load;

    // Handshake decode. Acceptance is gated by rst_n so that nothing is written
    // while the block is held in reset. A load can only be accepted in IDLE. In
    // IDLE with no stall the buffer is necessarily empty.
    always_comb begin
        Stall       = buf_valid | (LoadReq & (state != IDLE));
        MemReq      = (state == WAIT);
        load_wb     = (state == WAIT) & MemAck;
        alu_accept  = rst_n & AluValid & ~Stall;
        load_accept = rst_n & LoadReq & ~Stall & (state == IDLE);
        buf_load    = load_wb & alu_accept;
    end

    // Writeback mux, in priority order: buffered ALU entry, load data, fresh
    // ALU result. The buffered entry and the load writeback never coincide,
    // because the buffer is only filled in an ack cycle and the FSM is then
    // back in IDLE. Register 0 is never written, but the handshake still
    // completes.
    always_comb begin
        RegWrite    = 1'b0;
        ResultSrc   = 1'b0;
        WbRd        = '0;
        WbALUResult = '0;
        if (buf_valid) begin
            WbRd        = buf_rd;
            WbALUResult = buf_data;
            RegWrite    = (buf_rd != '0);
        end else if (load_wb) begin
            ResultSrc   = 1'b1;
            WbRd        = pend_rd;
            RegWrite    = (pend_rd != '0);
        end else if (alu_accept) begin
            WbRd        = AluRd;
            WbALUResult = ALUResult;
            RegWrite    = (AluRd != '0);
        end
    end

    // Next-state logic. MemAck seen in IDLE is a stray acknowledge, for example
    // from a load abandoned by reset, so it is deliberately ignored.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (load_accept) next_state = WAIT;
            WAIT:    if (MemAck)      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register. Reset abandons any outstanding load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Pending load destination and the one-entry ALU buffer. The buffer lives
    // exactly one cycle. While it is valid, Stall blocks any new ALU
    // acceptance, so buf_load cannot refill it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_rd   <= '0;
            buf_valid <= 1'b0;
            buf_rd    <= '0;
            buf_data  <= '0;
        end else begin
            if (load_accept) begin
                pend_rd <= LoadRd;
            end
            buf_valid <= buf_load;
            if (buf_load) begin
                buf_rd   <= AluRd;
                buf_data <= ALUResult;
            end
        end
    end

    // Stall-cycle counter. It saturates instead of wrapping, so a long
    // stalled run still reads as "very long".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCount <= '0;
        end else if (Stall && (StallCount != 16'hFFFF)) begin
            StallCount <= StallCount + 16'd1;
        end
    end

endmodule

// File: tb/tb_writeback_sequencer.sv
// tb_writeback_sequencer
//
// Purpose: directed test of writeback_sequencer. Each expected register write
// is queued when its stimulus is driven. An independent monitor pops and
// compares the queued entry on every cycle in which the DUT asserts RegWrite.
// Handshake outputs (Stall, MemReq, StallCount) are checked inline
// mid-cycle.

module tb_writeback_sequencer;

    typedef struct packed {
        logic [4:0]  rd;
        logic        src;
        logic [31:0] data;
    } wb_t;

    logic        clk;
    logic        rst_n;
    logic        AluValid;
    logic [4:0]  AluRd;
    logic [31:0] ALUResult;
    logic        LoadReq;
    logic [4:0]  LoadRd;
    logic        MemReq;
    logic        MemAck;
    logic        Stall;
    logic        RegWrite;
    logic [4:0]  WbRd;
    logic        ResultSrc;
    logic [31:0] WbALUResult;
    logic [15:0] StallCount;

    wb_t expq[$];
    int  testsRun    = 0;
    int  testsFailed = 0;

    writeback_sequencer #(.Data_Width(32), .Reg_Width(5)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .AluValid(AluValid),
        .AluRd(AluRd),
        .ALUResult(ALUResult),
        .LoadReq(LoadReq),
        .LoadRd(LoadRd),
        .MemReq(MemReq),
        .MemAck(MemAck),
        .Stall(Stall),
        .RegWrite(RegWrite),
        .WbRd(WbRd),
        .ResultSrc(ResultSrc),
        .WbALUResult(WbALUResult),
        .StallCount(StallCount)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point; every check, inline or from the monitor, goes here.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge.
    task automatic applyStimulus(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                                 input logic lr, input logic [4:0] lrd, input logic ma);
        @(posedge clk);
        #1;
        AluValid  = av;
        AluRd     = ar;
        ALUResult = ad;
        LoadReq   = lr;
        LoadRd    = lrd;
        MemAck    = ma;
    endtask

    task automatic expectWrite(input logic [4:0] rd, input logic src, input logic [31:0] data);
        wb_t e;
        e.rd   = rd;
        e.src  = src;
        e.data = data;
        expq.push_back(e);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    endtask

    // Monitor: every write the DUT performs must match the oldest queued
    // expectation. The ALU value is only meaningful when the mux selects it.
    always @(negedge clk) begin
        wb_t e;
        if (rst_n && RegWrite) begin
            if (expq.size() == 0) begin
                checkOutput("unexpected_write_rd", {27'd0, WbRd}, 32'hFFFF_FFFF);
            end else begin
                e = expq.pop_front();
                checkOutput("wb_rd", {27'd0, WbRd}, {27'd0, e.rd});
                checkOutput("wb_src", {31'd0, ResultSrc}, {31'd0, e.src});
                if (!e.src) begin
                    checkOutput("wb_alu_result", WbALUResult, e.data);
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        AluValid  = 1'b1;
        AluRd     = 5'd3;
        ALUResult = 32'h1234;
        LoadReq   = 1'b0;
        LoadRd    = 5'd0;
        MemAck    = 1'b0;

        // Reset holds everything quiet even while an ALU result is offered.
        #7;
        checkOutput("reset_regwrite", {31'd0, RegWrite}, 32'd0);
        checkOutput("reset_memreq", {31'd0, MemReq}, 32'd0);
        checkOutput("reset_stallcount", {16'd0, StallCount}, 32'd0);
        #5;
        AluValid = 1'b0;
        rst_n    = 1'b1;

        // ALU result in IDLE is written in the same cycle.
        applyStimulus(1'b1, 5'd3, 32'h1234, 1'b0, 5'd0, 1'b0);
        expectWrite(5'd3, 1'b0, 32'h1234);
        @(negedge clk);
        checkOutput("alu_stall", {31'd0, Stall}, 32'd0);

        // Quiet cycle drives zeros on the write port.
        idleCycle();
        @(negedge clk);
        checkOutput("idle_wbrd", {27'd0, WbRd}, 32'd0);
        checkOutput("idle_wbdata", WbALUResult, 32'd0);
        checkOutput("idle_src", {31'd0, ResultSrc}, 32'd0);

        // Load to r7 acknowledged in its third WAIT cycle.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0);
        @(negedge clk);
        checkOutput("load7_issue_memreq", {31'd0, MemReq}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
            @(negedge clk);
            checkOutput("load7_wait_memreq", {31'd0, MemReq}, 32'd1);
            checkOutput("load7_wait_regwrite", {31'd0, RegWrite}, 32'd0);
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
        expectWrite(5'd7, 1'b1, 32'h0);
        @(negedge clk);
        checkOutput("load7_ack_memreq", {31'd0, MemReq}, 32'd1);
        idleCycle();
        @(negedge clk);
        checkOutput("load7_after_memreq", {31'd0, MemReq}, 32'd0);

        // ALU result collides with load data: the load goes first, the ALU result next cycle.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0);
        applyStimulus(1'b1, 5'd5, 32'hABCD, 1'b0, 5'd0, 1'b1);
        expectWrite(5'd2, 1'b1, 32'h0);
        expectWrite(5'd5, 1'b0, 32'hABCD);
        @(negedge clk);
        checkOutput("collide_ack_stall", {31'd0, Stall}, 32'd0);
        idleCycle();
        @(negedge clk);
        checkOutput("collide_buf_stall", {31'd0, Stall}, 32'd1);
        idleCycle();
        @(negedge clk);
        checkOutput("collide_after_stall", {31'd0, Stall}, 32'd0);

        // Second load while one is outstanding stalls until back in IDLE.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0);
        @(negedge clk);
        checkOutput("load9_wait_stall", {31'd0, Stall}, 32'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1);
        expectWrite(5'd4, 1'b1, 32'h0);
        @(negedge clk);
        checkOutput("load9_ack_stall", {31'd0, Stall}, 32'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0);
        @(negedge clk);
        checkOutput("load9_accept_stall", {31'd0, Stall}, 32'd0);
        checkOutput("load9_accept_memreq", {31'd0, MemReq}, 32'd0);
        // One collision cycle plus two blocked-load cycles so far.
        checkOutput("stallcount_3", {16'd0, StallCount}, 32'd3);
        // Earliest possible acknowledge: the first WAIT cycle.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
        expectWrite(5'd9, 1'b1, 32'h0);
        @(negedge clk);
        checkOutput("load9_memreq", {31'd0, MemReq}, 32'd1);

        // Writes to register 0 are suppressed; the handshakes still complete.
        applyStimulus(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        checkOutput("r0_alu_regwrite", {31'd0, RegWrite}, 32'd0);
        checkOutput("r0_alu_stall", {31'd0, Stall}, 32'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
        @(negedge clk);
        checkOutput("r0_load_memreq", {31'd0, MemReq}, 32'd1);
        checkOutput("r0_load_regwrite", {31'd0, RegWrite}, 32'd0);
        // A stray acknowledge in IDLE does nothing.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
        @(negedge clk);
        checkOutput("stray_ack_regwrite", {31'd0, RegWrite}, 32'd0);
        checkOutput("stray_ack_memreq", {31'd0, MemReq}, 32'd0);
        idleCycle();
        @(negedge clk);
        checkOutput("stray_ack_after_memreq", {31'd0, MemReq}, 32'd0);

        // Reset during WAIT abandons the load; the later ack is ignored.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 1'b0);
        idleCycle();
        @(negedge clk);
        checkOutput("rstwait_memreq", {31'd0, MemReq}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        checkOutput("rstwait_memreq_low", {31'd0, MemReq}, 32'd0);
        checkOutput("rstwait_stallcount", {16'd0, StallCount}, 32'd0);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
        @(negedge clk);
        checkOutput("rstwait_ack_regwrite", {31'd0, RegWrite}, 32'd0);
        checkOutput("rstwait_ack_memreq", {31'd0, MemReq}, 32'd0);

        // Long stall: load r8 and keep requesting another load with no ack.
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 1'b0);
        @(posedge clk);
        repeat (100) @(posedge clk);
        #1;
        checkOutput("stallcount_100", {16'd0, StallCount}, 32'd100);
        repeat (69900) @(posedge clk);
        #1;
        checkOutput("stallcount_sat", {16'd0, StallCount}, 32'h0000_FFFF);
        MemAck  = 1'b1;
        LoadReq = 1'b0;
        expectWrite(5'd8, 1'b1, 32'h0);
        @(negedge clk);
        checkOutput("sat_ack_memreq", {31'd0, MemReq}, 32'd1);
        idleCycle();
        idleCycle();
        @(negedge clk);
        checkOutput("stallcount_hold", {16'd0, StallCount}, 32'h0000_FFFF);
        checkOutput("queue_empty", expq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
